alu_mdu: RTL
============

# alu_mdu

Parametrised execute-stage ALU with an iterative multiply/divide unit, replacing the purely combinational ALU in the pipeline's EX stage. Single-cycle ops return a registered result one cycle after acceptance. Signed/unsigned multiply and divide run a shift-add / restoring-divide loop over WIDTH cycles behind a valid/ready handshake, and produce a HI word (product high half or remainder) as well as the low result.

## Interface
- WIDTH, 32, operand/result width; power of two, ≥ 8
- CTRL_WIDTH, 4, width of the op-select field
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  asynchronous, active-low reset
- in_valid_i  in  1  operands and op present
- in_ready_o  out  1  block can accept this cycle
- src1_i  in  WIDTH  operand 1; shift amount for shifts
- src2_i  in  WIDTH  operand 2; value shifted for shifts
- ALU_control_i  in  CTRL_WIDTH  op select
- out_valid_o  out  1  result_o/hi_o/overflow_o valid; one-cycle pulse
- result_o  out  WIDTH  result, product low half, or quotient
- hi_o  out  WIDTH  product high half or remainder; 0 for single-cycle ops
- overflow_o  out  1  signed overflow for add/sub; 0 otherwise

## Operation
- Op codes (single-cycle unless noted):
  - 0000 and; 0001 or; 0010 add; 0011 xor; 0100 nor
  - 0101 sltu; 0110 sub; 0111 slt
  - 1000 sll; 1001 srl; 1010 sra
  - multi-cycle: 1011 mult (signed), 1100 multu, 1101 div (signed), 1110 divu
  - 1111 reserved: result 0, single-cycle
- Shifts move src2_i by src1_i[$clog2(WIDTH)-1:0]; upper bits of src1_i are ignored.
- slt/sltu write 1 or 0, zero-extended to WIDTH.
- overflow_o is set on add when the operand signs are equal and the result sign differs. It is set on sub when the operand signs differ and the result sign differs from src1.
- Acceptance happens at a rising edge where in_valid_i && in_ready_o.
  - in_valid_i while in_ready_o=0 is ignored. The requester holds its request until accepted.
- FSM states: IDLE, BUSY, FIX.
  - IDLE: in_ready_o=1.
    - Single-cycle op accepted: outputs registered, out_valid_o=1 next cycle, stay IDLE.
    - Multi-cycle op accepted: latch operand magnitudes (signed ops) or raw operands (unsigned ops), latch the result-sign flags, clear the iteration counter, go to BUSY.
  - BUSY: in_ready_o=0. Process one bit per cycle, WIDTH iterations (counter 0..WIDTH-1), then go to FIX.
    - Multiply: 2·WIDTH-bit shift-add.
    - Divide: restoring; remainder register WIDTH+1 bits.
  - FIX: in_ready_o=0. Apply two's-complement sign correction, register result_o/hi_o, pulse out_valid_o, go to IDLE.
- Sign rules:
  - Product is negated when the operand signs differ.
  - Quotient is negated when the signs differ.
  - Remainder takes the dividend's sign.
- Divide by zero: quotient all ones, remainder = src1 (unmodified).
- Signed MIN / −1: quotient MIN, remainder 0. This falls out of the magnitude algorithm and needs no special case.
- Outputs hold their last values when out_valid_o=0.

## Timing
- Reset (async assert, sync release): state IDLE; out_valid_o=0, result_o=0, hi_o=0, overflow_o=0, in_ready_o=1. Internal counter and operand registers are cleared.
- Reset asserted mid-operation aborts the op. No out_valid_o is produced for it.
- Single-cycle latency: accepted at edge N, out_valid_o high during cycle N..N+1.
- Multi-cycle latency, for an op accepted at edge N:
  - edges N+1..N+WIDTH run the iterations;
  - edge N+WIDTH+1 executes FIX;
  - out_valid_o is high for the cycle after that edge.
  - Total latency is WIDTH+1 cycles (33 at WIDTH=32), identical for multiply and divide.
- in_ready_o rises in the same cycle out_valid_o pulses. A new op can be accepted at that edge, so ops run back to back with no bubble.
- No output backpressure. The consumer must capture the result on out_valid_o.

## Test plan
- Reset/idle: hold rst_n_i=0 → all outputs 0, in_ready_o=1. Then add 3+4 → out_valid_o one cycle later, result_o=7, hi_o=0.
- Single-cycle edge cases:
  - add 0x7FFFFFFF+1 → 0x80000000, overflow_o=1
  - slt 0xFFFFFFFF,1 → 1
  - sltu 0xFFFFFFFF,1 → 0
  - sra src1=0x24 (uses 4), src2=0x80000000 → 0xF8000000
- Multiply, each with out_valid_o exactly 33 cycles after accept and in_ready_o=0 in between:
  - mult −3×5 → result_o=0xFFFFFFF1, hi_o=0xFFFFFFFF
  - multu 0xFFFFFFFF×2 → result_o=0xFFFFFFFE, hi_o=0x00000001
- Divide:
  - div −7/2 → 0xFFFFFFFD rem 0xFFFFFFFF
  - divu 100/7 → 14 rem 2
  - div 5/0 → 0xFFFFFFFF rem 5
  - div 0x80000000/0xFFFFFFFF → 0x80000000 rem 0
- Handshake:
  - in_valid_i held during BUSY → ignored.
  - Op issued in the out_valid_o cycle → accepted.
  - Back-to-back mult, then add → add result one cycle after its accept.
- Reset mid-op: assert rst_n_i at iteration 10 of a div → no out_valid_o. Next op after release completes correctly.

Source files
------------

// File: rtl/alu_mdu.sv
// alu_mdu: execute-stage ALU with an iterative signed/unsigned multiply/divide unit
//
// Ports:
//   clk_i          rising-edge clock
//   rst_n_i        asynchronous active-low reset
//   in_valid_i     operands and op present
//   in_ready_o     block can accept this cycle (high only in IDLE)
//   src1_i         operand 1; shift amount for shifts
//   src2_i         operand 2; value shifted for shifts
//   ALU_control_i  op select
//   out_valid_o    one-cycle pulse marking result_o/hi_o/overflow_o valid
//   result_o       result, product low half, or quotient
//   hi_o           product high half or remainder; 0 for single-cycle ops
//   overflow_o     signed overflow for add/sub; 0 otherwise
module alu_mdu #(
    parameter int WIDTH      = 32,
    parameter int CTRL_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [WIDTH-1:0]      src1_i,
    input  logic [WIDTH-1:0]      src2_i,
    input  logic [CTRL_WIDTH-1:0] ALU_control_i,
    output logic                  out_valid_o,
    output logic [WIDTH-1:0]      result_o,
    output logic [WIDTH-1:0]      hi_o,
    output logic                  overflow_o
);
    localparam int SW = $clog2(WIDTH);
    localparam logic [CTRL_WIDTH-1:0] OP_AND   = CTRL_WIDTH'(0);
    localparam logic [CTRL_WIDTH-1:0] OP_OR    = CTRL_WIDTH'(1);
    localparam logic [CTRL_WIDTH-1:0] OP_ADD   = CTRL_WIDTH'(2);
    localparam logic [CTRL_WIDTH-1:0] OP_XOR   = CTRL_WIDTH'(3);
    localparam logic [CTRL_WIDTH-1:0] OP_NOR   = CTRL_WIDTH'(4);
    localparam logic [CTRL_WIDTH-1:0] OP_SLTU  = CTRL_WIDTH'(5);
    localparam logic [CTRL_WIDTH-1:0] OP_SUB   = CTRL_WIDTH'(6);
    localparam logic [CTRL_WIDTH-1:0] OP_SLT   = CTRL_WIDTH'(7);
    localparam logic [CTRL_WIDTH-1:0] OP_SLL   = CTRL_WIDTH'(8);
    localparam logic [CTRL_WIDTH-1:0] OP_SRL   = CTRL_WIDTH'(9);
    localparam logic [CTRL_WIDTH-1:0] OP_SRA   = CTRL_WIDTH'(10);
    localparam logic [CTRL_WIDTH-1:0] OP_MULT  = CTRL_WIDTH'(11);
    localparam logic [CTRL_WIDTH-1:0] OP_MULTU = CTRL_WIDTH'(12);
    localparam logic [CTRL_WIDTH-1:0] OP_DIV   = CTRL_WIDTH'(13);
    localparam logic [CTRL_WIDTH-1:0] OP_DIVU  = CTRL_WIDTH'(14);

    typedef enum logic [1:0] {IDLE, BUSY, FIX} state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_q, a_d;       // multiplicand or divisor magnitude
    logic [WIDTH-1:0]  b_q, b_d;       // multiplier / product low, or dividend / quotient
    logic [WIDTH:0]    acc_q, acc_d;   // product high (with carry) or remainder
    logic              mul_q, mul_d;
    logic              neg_lo_q, neg_lo_d;
    logic              neg_hi_q, neg_hi_d;
    logic              valid_q, valid_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic              ovf_q, ovf_d;

    logic [SW-1:0]      sh;
    logic [WIDTH-1:0]   sum, diff, alu_res;
    logic               alu_ovf;
    logic               is_multi, is_mul, is_signed, s1_neg, s2_neg;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic               div_take;
    logic [2*WIDTH-1:0] prod, fix_prod;

    always_comb begin
        sh      = src1_i[SW-1:0];
        sum     = src1_i + src2_i;
        diff    = src1_i - src2_i;
        alu_ovf = 1'b0;
        case (ALU_control_i)
            OP_AND:  alu_res = src1_i & src2_i;
            OP_OR:   alu_res = src1_i | src2_i;
            OP_ADD:  begin
                alu_res = sum;
                alu_ovf = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) && (sum[WIDTH-1] != src1_i[WIDTH-1]);
            end
            OP_XOR:  alu_res = src1_i ^ src2_i;
            OP_NOR:  alu_res = ~(src1_i | src2_i);
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, src1_i < src2_i};
            OP_SUB:  begin
                alu_res = diff;
                alu_ovf = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) && (diff[WIDTH-1] != src1_i[WIDTH-1]);
            end
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(src1_i) < $signed(src2_i)};
            OP_SLL:  alu_res = src2_i << sh;
            OP_SRL:  alu_res = src2_i >> sh;
            OP_SRA:  alu_res = $signed(src2_i) >>> sh;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        is_mul    = (ALU_control_i == OP_MULT) || (ALU_control_i == OP_MULTU);
        is_multi  = is_mul || (ALU_control_i == OP_DIV) || (ALU_control_i == OP_DIVU);
        is_signed = (ALU_control_i == OP_MULT) || (ALU_control_i == OP_DIV);
        s1_neg    = is_signed & src1_i[WIDTH-1];
        s2_neg    = is_signed & src2_i[WIDTH-1];
        mag1      = s1_neg ? -src1_i : src1_i;
        mag2      = s2_neg ? -src2_i : src2_i;
        mul_sum   = {1'b0, acc_q[WIDTH-1:0]} + (b_q[0] ? {1'b0, a_q} : '0);
        div_shift = {acc_q[WIDTH-1:0], b_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, a_q};
        // Remainder stays below the divisor, so a set top bit can only mean a borrow
        div_take  = ~div_diff[WIDTH];
        prod      = {acc_q[WIDTH-1:0], b_q};
        fix_prod  = neg_lo_q ? -prod : prod;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        mul_d    = mul_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        valid_d  = 1'b0;
        result_d = result_q;
        hi_d     = hi_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: if (in_valid_i) begin
                if (is_multi) begin
                    state_d  = BUSY;
                    cnt_d    = '0;
                    acc_d    = '0;
                    mul_d    = is_mul;
                    a_d      = is_mul ? mag1 : mag2;
                    b_d      = is_mul ? mag2 : mag1;
                    // Divide by zero keeps the all-ones quotient unsigned; the
                    // remainder magnitude re-signed with the dividend sign equals src1
                    neg_lo_d = (s1_neg ^ s2_neg) & (is_mul | (|src2_i));
                    neg_hi_d = s1_neg;
                end else begin
                    valid_d  = 1'b1;
                    result_d = alu_res;
                    hi_d     = '0;
                    ovf_d    = alu_ovf;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + SW'(1);
                if (mul_q)
                    {acc_d, b_d} = {mul_sum, b_q} >> 1;
                else begin
                    acc_d = div_take ? div_diff : div_shift;
                    b_d   = {b_q[WIDTH-2:0], div_take};
                end
                if (cnt_q == SW'(WIDTH-1))
                    state_d = FIX;
            end
            default: begin
                state_d  = IDLE;
                valid_d  = 1'b1;
                ovf_d    = 1'b0;
                result_d = mul_q ? fix_prod[WIDTH-1:0] : (neg_lo_q ? -b_q : b_q);
                hi_d     = mul_q ? fix_prod[2*WIDTH-1:WIDTH] : (neg_hi_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            mul_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
            hi_q     <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            mul_q    <= mul_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = valid_q;
    assign result_o    = result_q;
    assign hi_o        = hi_q;
    assign overflow_o  = ovf_q;
endmodule
